jk_excite_ctrl: RTL and testbench
=================================

Name: jk_excite_ctrl

Overview:
Controller that drives a WIDTH-bit bank of external JK flip-flops to a requested target value, one word at a time. It is the driving end of the JK flop interface, solving the inverse problem of the flop. A target word arrives on a valid/ready handshake. The block computes per-bit J/K from the JK excitation table against the bank's fed-back Q, pulses the bank enable for one cycle, then checks that the bank landed on the target, retrying on mismatch.

Parameters:
WIDTH, 4, number of JK flops in the driven bank
DC_FILL, 0, don't-care resolution: 0 = fill with 0; 1 = toggle form (J=K)
MAX_RETRY, 2, re-drive attempts after a failed check before flagging an error

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (asserted at 0)
tgt_valid  input  1  target word offered
tgt_data  input  WIDTH  requested next Q of the bank
tgt_ready  output  1  block can accept a target
q_fb  input  WIDTH  current Q of the external JK bank
j_out  output  WIDTH  J inputs to the bank
k_out  output  WIDTH  K inputs to the bank
jk_en  output  1  bank clock-enable, one-cycle pulse
done  output  1  one-cycle pulse: bank matched target
err  output  1  one-cycle pulse: retries exhausted
err_flag  output  1  sticky error, cleared by err_clr
err_clr  input  1  clears err_flag

Behaviour:
- Reset (rst=0, any time including mid-operation): state is IDLE immediately. All of the following are 0: j_out, k_out, jk_en, done, err, err_flag, retry count, latched target. tgt_ready is 0 while rst=0 and 1 from the first cycle after release.
- States are IDLE, DRIVE and CHECK.
- IDLE:
  - tgt_ready=1; j_out, k_out and jk_en are 0, so the bank holds.
  - On tgt_valid&tgt_ready: latch tgt_data, clear the retry count, register J/K computed from the current q_fb, and go to DRIVE.
- DRIVE (one cycle):
  - jk_en=1; j_out/k_out present the registered values; tgt_ready=0.
  - The bank updates on the edge ending this cycle. Next state is CHECK.
- CHECK (one cycle):
  - tgt_ready=0, jk_en=0, J/K=0.
  - If q_fb==target: go to IDLE and raise done for exactly the following cycle.
  - Else if retry count < MAX_RETRY: increment it, recompute J/K from the current q_fb, and go to DRIVE.
  - Else: go to IDLE, raise err for one cycle, and set err_flag.
- Latency: with no retries, done is high 3 cycles after the accept edge. Each retry adds 2 cycles.
- A new target may be accepted in the same cycle done or err is high, since that cycle is IDLE. This gives back-to-back throughput of one word per 3 cycles.
- Excitation per bit, written q->t : J,K:
  - 0->0 : 0,x
  - 0->1 : 1,x
  - 1->0 : x,1
  - 1->1 : x,0
- Don't-care fill:
  - DC_FILL=0: x=0. Gives 0->1 as J=1,K=0 and 1->0 as J=0,K=1.
  - DC_FILL=1: x chosen so J=K. Gives 0->1 and 1->0 as J=K=1; holds are J=K=0.
- J/K are recomputed from q_fb on every retry, never reused, so a partially-landed bank is corrected bitwise.
- err_clr=1 clears err_flag on the next edge. If err is set in the same cycle, set wins.
- Inputs tgt_data and tgt_valid are ignored outside IDLE. q_fb is sampled only in IDLE (on accept) and CHECK.

Decomposition:
- Package jk_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK);
  - the DC_FILL encodings as named constants;
  - a function returning the {J,K} pair for (q, t, dc_fill).
- Sub-module jk_excite: purely combinational, WIDTH-wide, maps (q_fb, target, DC_FILL) to (j, k) using the package function. The controller FSM, counter and flags stay in jk_excite_ctrl.

Test Plan:
- Bench contains a behavioural 4-bit JK bank clocked by clk and gated by jk_en.
- Reset/idle: hold rst=0 mid-DRIVE -> j_out=k_out=0, jk_en=0, done=0, err_flag=0, tgt_ready=0. Release -> tgt_ready=1 next cycle and the bank is untouched.
- Basic drive, DC_FILL=0: q_fb=4'b0011, tgt=4'b0101 -> during DRIVE j_out=4'b0100, k_out=4'b0010. Bank becomes 0101 and done pulses 3 cycles after accept.
- Toggle fill, DC_FILL=1: q_fb=4'b1010, tgt=4'b0110 -> j_out=k_out=4'b1100, bank reads 0110, done pulses.
- Retry then success: the bank model ignores bit0 on the first enable only. q=0000, tgt=0001 -> CHECK mismatch, second DRIVE with j_out=0001, done at cycle 5, err=0.
- Retry exhausted: bank stuck at 0000, tgt=1111, MAX_RETRY=2 -> three jk_en pulses, err pulse, err_flag=1. Then err_clr=1 -> err_flag=0.
- Back-to-back: tgt_valid held high with 1000 then 0001 -> second accept occurs in the done cycle, and the two dones are 3 cycles apart.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK bank excitation controller.
// Holds the FSM state encoding, the don't-care fill codes and the per-bit excitation function.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam int DC_FILL_ZERO   = 0;
    localparam int DC_FILL_TOGGLE = 1;

    // Returns {J,K} that moves one JK flop from q to t; dc_toggle resolves don't-cares so J==K
    function automatic logic [1:0] jk_pair(input logic q, input logic t, input logic dc_toggle);
        logic [1:0] jk;
        case ({q, t})
            2'b00:   jk = 2'b00;
            2'b01:   jk = {1'b1, dc_toggle};
            2'b10:   jk = {dc_toggle, 1'b1};
            2'b11:   jk = 2'b00;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation: per-bit J/K that take the bank from q_fb to tgt.
// Don't-care resolution is fixed at elaboration by DC_FILL.
import jk_pkg::*;

module jk_excite #(
    parameter int WIDTH   = 4,
    parameter int DC_FILL = DC_FILL_ZERO
) (
    input  logic [WIDTH-1:0] q_fb,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    localparam logic DC_TOGGLE_C = (DC_FILL == DC_FILL_TOGGLE);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] pair_s;
        assign pair_s = jk_pair(q_fb[i], tgt[i], DC_TOGGLE_C);
        assign j[i]   = pair_s[1];
        assign k[i]   = pair_s[0];
    end

endmodule

// File: rtl/jk_excite_ctrl.sv
// Drives an external JK flop bank to a requested word: excite, pulse enable, verify, retry.
// All outputs are registered; J/K are recomputed from the fed-back Q on every attempt.
import jk_pkg::*;

module jk_excite_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DC_FILL   = DC_FILL_ZERO,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             jk_en,
    output logic             done,
    output logic             err,
    output logic             err_flag,
    input  logic             err_clr
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX_C = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE_C = RW'(1);

    state_e           state_r, state_s;
    logic [WIDTH-1:0] tgt_r, tgt_s;
    logic [RW-1:0]    retry_r, retry_s;
    logic [WIDTH-1:0] j_r, j_s, k_r, k_s;
    logic             en_r, en_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic             flag_r, flag_s;
    logic             ready_r, ready_s;
    logic [WIDTH-1:0] exc_tgt_s, exc_j_s, exc_k_s;

    // In IDLE the excitation is computed against the word being offered, otherwise the latched one
    assign exc_tgt_s = (state_r == IDLE) ? tgt_data : tgt_r;

    jk_excite #(
        .WIDTH  (WIDTH),
        .DC_FILL(DC_FILL)
    ) u_excite (
        .q_fb(q_fb),
        .tgt (exc_tgt_s),
        .j   (exc_j_s),
        .k   (exc_k_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        tgt_s   = tgt_r;
        retry_s = retry_r;
        j_s     = '0;
        k_s     = '0;
        en_s    = 1'b0;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (tgt_valid && ready_r) begin
                    tgt_s   = tgt_data;
                    retry_s = '0;
                    j_s     = exc_j_s;
                    k_s     = exc_k_s;
                    en_s    = 1'b1;
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                state_s = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_r) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (retry_r < RETRY_MAX_C) begin
                    retry_s = retry_r + RETRY_ONE_C;
                    j_s     = exc_j_s;
                    k_s     = exc_k_s;
                    en_s    = 1'b1;
                    state_s = DRIVE;
                end else begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        ready_s = (state_s == IDLE);
        // A new error outranks a simultaneous clear
        if (err_s) begin
            flag_s = 1'b1;
        end else if (err_clr) begin
            flag_s = 1'b0;
        end else begin
            flag_s = flag_r;
        end
    end

    // State, latched target, retry count and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            tgt_r   <= '0;
            retry_r <= '0;
            j_r     <= '0;
            k_r     <= '0;
            en_r    <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            flag_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            tgt_r   <= tgt_s;
            retry_r <= retry_s;
            j_r     <= j_s;
            k_r     <= k_s;
            en_r    <= en_s;
            done_r  <= done_s;
            err_r   <= err_s;
            flag_r  <= flag_s;
            ready_r <= ready_s;
        end
    end

    assign tgt_ready = ready_r;
    assign j_out     = j_r;
    assign k_out     = k_r;
    assign jk_en     = en_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_flag  = flag_r;

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Bench for jk_excite_ctrl: two instances (zero fill and toggle fill) each driving a behavioural
// 4-bit JK bank; expected outcomes are queued at stimulus time and popped on done/err.
module tb_jk_excite_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       tgt_valid0 = 1'b0, tgt_valid1 = 1'b0, err_clr = 1'b0;
    logic [3:0] tgt_data = 4'b0000;
    logic       tgt_ready0, tgt_ready1;
    logic [3:0] q0 = 4'b0000, q1 = 4'b0000;
    logic [3:0] j0, k0, j1, k1;
    logic       jk_en0, jk_en1, done0, done1, err0, err1, flag0, flag1;

    logic       ld0 = 1'b0, ld1 = 1'b0, stuck0 = 1'b0;
    logic [3:0] ldv = 4'b0000, ign_mask0 = 4'b0000;
    int         ign_at0 = 0, en_cnt0 = 0;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] tgt;
        logic       is_err;
        int         lat;
    } exp_t;
    exp_t sb[$];

    jk_excite_ctrl #(.WIDTH(4), .DC_FILL(0), .MAX_RETRY(2)) dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid0), .tgt_data(tgt_data), .tgt_ready(tgt_ready0),
        .q_fb(q0), .j_out(j0), .k_out(k0), .jk_en(jk_en0), .done(done0), .err(err0),
        .err_flag(flag0), .err_clr(err_clr)
    );

    jk_excite_ctrl #(.WIDTH(4), .DC_FILL(1), .MAX_RETRY(2)) dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid1), .tgt_data(tgt_data), .tgt_ready(tgt_ready1),
        .q_fb(q1), .j_out(j1), .k_out(k1), .jk_en(jk_en1), .done(done1), .err(err1),
        .err_flag(flag1), .err_clr(1'b0)
    );

    // JK flop characteristic with optional per-bit ignore mask
    function automatic logic [3:0] bank_next(input logic [3:0] q, input logic [3:0] j,
                                             input logic [3:0] k, input logic [3:0] m);
        logic [3:0] nq;
        nq = (j & ~q) | (~k & q);
        return (nq & ~m) | (q & m);
    endfunction

    always @(posedge clk) begin
        if (ld0) q0 <= ldv;
        else if (jk_en0) begin
            en_cnt0 <= en_cnt0 + 1;
            if (!stuck0) q0 <= bank_next(q0, j0, k0, (en_cnt0 == ign_at0) ? ign_mask0 : 4'b0000);
        end
    end

    always @(posedge clk) begin
        if (ld1) q1 <= ldv;
        else if (jk_en1) q1 <= bank_next(q1, j1, k1, 4'b0000);
    end

    task automatic load_bank0(input logic [3:0] v);
        ldv = v; ld0 = 1'b1;
        @(negedge clk);
        ld0 = 1'b0;
    endtask

    task automatic load_bank1(input logic [3:0] v);
        ldv = v; ld1 = 1'b1;
        @(negedge clk);
        ld1 = 1'b0;
    endtask

    task automatic offer0(input logic [3:0] t, input logic is_err, input int lat);
        exp_t e;
        e.tgt = t; e.is_err = is_err; e.lat = lat;
        tgt_data = t;
        tgt_valid0 = 1'b1;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done0/err0; n is the cycle index since accept, -1 on timeout
    task automatic wait_evt0(input int n0, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done0 || err0) begin
                n = n0 + i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (tgt_ready0 !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", tgt_ready0); end
        checks++; if ({j0, k0, jk_en0, done0, err0, flag0} !== 12'h000) begin
            errs++; $display("FAIL rst_outs: got %b want 0", {j0, k0, jk_en0, done0, err0, flag0}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tgt_ready0 !== 1'b1) begin errs++; $display("FAIL rel_ready: got %b want 1", tgt_ready0); end
        load_bank0(4'b0000);
        tgt_data = 4'b1111; tgt_valid0 = 1'b1;
        @(negedge clk);
        tgt_valid0 = 1'b0;
        checks++; if (jk_en0 !== 1'b1) begin errs++; $display("FAIL mid_drive_en: got %b want 1", jk_en0); end
        rst = 1'b0;
        #1;
        checks++; if ({j0, k0, jk_en0, done0, flag0, tgt_ready0} !== 12'h000) begin
            errs++; $display("FAIL mid_rst_outs: got %b want 0", {j0, k0, jk_en0, done0, flag0, tgt_ready0}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tgt_ready0 !== 1'b1) begin errs++; $display("FAIL mid_rel_ready: got %b want 1", tgt_ready0); end
        checks++; if (q0 !== 4'b0000) begin errs++; $display("FAIL mid_rst_bank: got %b want 0000", q0); end
    endtask

    task automatic test_basic();
        exp_t e;
        int   n;
        load_bank0(4'b0011);
        offer0(4'b0101, 1'b0, 3);
        @(negedge clk);
        tgt_valid0 = 1'b0;
        checks++; if (jk_en0 !== 1'b1) begin errs++; $display("FAIL basic_en: got %b want 1", jk_en0); end
        checks++; if (j0 !== 4'b0100) begin errs++; $display("FAIL basic_j: got %b want 0100", j0); end
        checks++; if (k0 !== 4'b0010) begin errs++; $display("FAIL basic_k: got %b want 0010", k0); end
        checks++; if (tgt_ready0 !== 1'b0) begin errs++; $display("FAIL basic_ready: got %b want 0", tgt_ready0); end
        wait_evt0(1, n);
        e = sb.pop_front();
        checks++; if (n !== e.lat) begin errs++; $display("FAIL basic_lat: got %0d want %0d", n, e.lat); end
        checks++; if ({done0, err0} !== {~e.is_err, e.is_err}) begin
            errs++; $display("FAIL basic_kind: got done=%b err=%b want err=%b", done0, err0, e.is_err); end
        checks++; if (q0 !== e.tgt) begin errs++; $display("FAIL basic_bank: got %b want %b", q0, e.tgt); end
        @(negedge clk);
        checks++; if (done0 !== 1'b0) begin errs++; $display("FAIL basic_pulse: got %b want 0", done0); end
    endtask

    task automatic test_toggle();
        exp_t e;
        int   n;
        load_bank1(4'b1010);
        e.tgt = 4'b0110; e.is_err = 1'b0; e.lat = 3;
        tgt_data = 4'b0110; tgt_valid1 = 1'b1;
        sb.push_back(e);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                tgt_valid1 = 1'b0;
                checks++; if (j1 !== 4'b1100) begin errs++; $display("FAIL tog_j: got %b want 1100", j1); end
                checks++; if (k1 !== 4'b1100) begin errs++; $display("FAIL tog_k: got %b want 1100", k1); end
            end
            if (done1 || err1) begin
                n = i;
                break;
            end
        end
        e = sb.pop_front();
        checks++; if (n !== e.lat) begin errs++; $display("FAIL tog_lat: got %0d want %0d", n, e.lat); end
        checks++; if (done1 !== 1'b1) begin errs++; $display("FAIL tog_done: got %b want 1", done1); end
        checks++; if (q1 !== e.tgt) begin errs++; $display("FAIL tog_bank: got %b want %b", q1, e.tgt); end
    endtask

    task automatic test_retry();
        exp_t e;
        int   n;
        load_bank0(4'b0000);
        ign_at0 = en_cnt0; ign_mask0 = 4'b0001;
        offer0(4'b0001, 1'b0, 5);
        @(negedge clk);
        tgt_valid0 = 1'b0;
        checks++; if (j0 !== 4'b0001) begin errs++; $display("FAIL retry_j1: got %b want 0001", j0); end
        @(negedge clk);
        checks++; if ({jk_en0, done0, q0} !== 6'b000000) begin
            errs++; $display("FAIL retry_check: got %b want 000000", {jk_en0, done0, q0}); end
        @(negedge clk);
        checks++; if ({jk_en0, j0, k0} !== 9'b1_0001_0000) begin
            errs++; $display("FAIL retry_drive2: got %b want 100010000", {jk_en0, j0, k0}); end
        wait_evt0(3, n);
        e = sb.pop_front();
        checks++; if (n !== e.lat) begin errs++; $display("FAIL retry_lat: got %0d want %0d", n, e.lat); end
        checks++; if ({done0, err0} !== 2'b10) begin errs++; $display("FAIL retry_kind: got %b want 10", {done0, err0}); end
        checks++; if (q0 !== e.tgt) begin errs++; $display("FAIL retry_bank: got %b want %b", q0, e.tgt); end
        ign_mask0 = 4'b0000;
    endtask

    task automatic test_exhaust();
        exp_t e;
        int   n;
        int   pulses;
        load_bank0(4'b0000);
        stuck0 = 1'b1;
        pulses = 0;
        offer0(4'b1111, 1'b1, 7);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) tgt_valid0 = 1'b0;
            if (jk_en0) pulses++;
            if (i == 6) err_clr = 1'b1;
        end
        wait_evt0(6, n);
        err_clr = 1'b0;
        e = sb.pop_front();
        checks++; if (n !== e.lat) begin errs++; $display("FAIL exh_lat: got %0d want %0d", n, e.lat); end
        checks++; if ({done0, err0} !== {~e.is_err, e.is_err}) begin
            errs++; $display("FAIL exh_kind: got done=%b err=%b want err=%b", done0, err0, e.is_err); end
        checks++; if (flag0 !== 1'b1) begin errs++; $display("FAIL exh_flag_set: got %b want 1", flag0); end
        checks++; if (pulses !== 3) begin errs++; $display("FAIL exh_pulses: got %0d want 3", pulses); end
        @(negedge clk);
        checks++; if ({flag0, err0} !== 2'b10) begin errs++; $display("FAIL exh_sticky: got %b want 10", {flag0, err0}); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (flag0 !== 1'b0) begin errs++; $display("FAIL exh_clr: got %b want 0", flag0); end
        stuck0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        load_bank0(4'b0000);
        offer0(4'b1000, 1'b0, 3);
        @(negedge clk);
        offer0(4'b0001, 1'b0, 6);
        wait_evt0(1, n);
        e = sb.pop_front();
        checks++; if (n !== e.lat) begin errs++; $display("FAIL b2b_lat1: got %0d want %0d", n, e.lat); end
        checks++; if ({done0, tgt_ready0} !== 2'b11) begin
            errs++; $display("FAIL b2b_done_ready: got %b want 11", {done0, tgt_ready0}); end
        checks++; if (q0 !== e.tgt) begin errs++; $display("FAIL b2b_bank1: got %b want %b", q0, e.tgt); end
        @(negedge clk);
        tgt_valid0 = 1'b0;
        checks++; if ({jk_en0, tgt_ready0, j0, k0} !== 10'b10_0001_1000) begin
            errs++; $display("FAIL b2b_drive2: got %b want 1000011000", {jk_en0, tgt_ready0, j0, k0}); end
        wait_evt0(4, n);
        e = sb.pop_front();
        checks++; if (n !== e.lat) begin errs++; $display("FAIL b2b_lat2: got %0d want %0d", n, e.lat); end
        checks++; if (done0 !== 1'b1) begin errs++; $display("FAIL b2b_done2: got %b want 1", done0); end
        checks++; if (q0 !== e.tgt) begin errs++; $display("FAIL b2b_bank2: got %b want %b", q0, e.tgt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_retry();
        test_exhaust();
        test_back_to_back();
        checks++; if (sb.size() !== 0) begin errs++; $display("FAIL sb_empty: got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
